// File: rtl/window_feeder.sv
// Raster-stream window assembler: keeps MAX_KERNEL-1 line buffers, builds the KxK
// neighbourhood and hands one window at a time to the kernel compute block.
module window_feeder #(
   parameter int unsigned  MAX_KERNEL = 3,
   parameter int unsigned  MAX_WIDTH  = 64,
   parameter int unsigned  MAX_HEIGHT = 64,
   localparam int unsigned WW         = $clog2(MAX_WIDTH + 1),
   localparam int unsigned WH         = $clog2(MAX_HEIGHT + 1),
   localparam int unsigned KW         = $clog2(MAX_KERNEL) + 1
) (
   input  logic                                        clk,
   input  logic                                        n_rst,
   input  logic                                        frame_start,
   input  logic [WW-1:0]                               img_width,
   input  logic [WH-1:0]                               img_height,
   input  logic [KW-1:0]                               kernel_size,
   input  logic [7:0]                                  pixel_in,
   input  logic                                        pixel_valid,
   output logic                                        pixel_ready,
   input  logic                                        compute_done,
   output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]  window,
   output logic                                        start,
   output logic                                        busy,
   output logic                                        frame_done
);

   localparam int unsigned NLB  = MAX_KERNEL - 1;
   localparam int unsigned LBIW = (NLB > 1) ? $clog2(NLB) : 1;
   localparam int unsigned CIW  = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] win_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_ISSUE  = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic [WW-1:0]                r_width;
   logic [WH-1:0]                r_height;
   logic [KW-1:0]                r_k;
   logic [WW-1:0]                r_col;
   logic [WH-1:0]                r_row;
   logic                         r_last_issue;
   logic                         r_pixel_ready;
   logic                         r_start;
   logic                         r_busy;
   logic                         r_frame_done;
   win_t                         r_window;
   logic [7:0]                   r_lb [NLB][MAX_WIDTH];

   logic [KW-1:0]                w_k_clamped;
   logic [CIW-1:0]               w_col_idx;
   logic                         w_accept;
   logic                         w_valid;
   logic                         w_last;
   logic                         w_col_wrap;
   logic [MAX_KERNEL-1:0][7:0]   w_lb_col;
   win_t                         w_shift;
   win_t                         w_win_next;

   assign pixel_ready = r_pixel_ready;
   assign start       = r_start;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;
   assign window      = r_window;

   assign w_col_idx  = CIW'(r_col);
   assign w_accept   = (r_state == S_ACCEPT) && pixel_valid;
   assign w_valid    = (32'(r_row) + 1 >= 32'(r_k)) && (32'(r_col) + 1 >= 32'(r_k));
   assign w_last     = (32'(r_row) + 1 == 32'(r_height)) && (32'(r_col) + 1 == 32'(r_width));
   assign w_col_wrap = (32'(r_col) + 1 >= 32'(r_width));

   // Kernel edge clamp: 0 behaves as 1, oversize behaves as MAX_KERNEL
   always_comb begin
      w_k_clamped = kernel_size;
      if (kernel_size == '0) begin
         w_k_clamped = KW'(1);
      end else if (32'(kernel_size) > MAX_KERNEL) begin
         w_k_clamped = KW'(MAX_KERNEL);
      end
   end

   // For K < MAX_KERNEL the window's top row reads the (K-1)th-newest buffer
   always_comb begin
      w_lb_col = '0;
      for (int unsigned y = 0; y < MAX_KERNEL; y++) begin
         if (y + 1 < 32'(r_k)) begin
            w_lb_col[y] = r_lb[LBIW'(MAX_KERNEL - 32'(r_k) + y)][w_col_idx];
         end
      end
   end

   // Next window: shift left within KxK, insert new column, zero everything outside
   always_comb begin
      w_shift    = '0;
      w_win_next = '0;
      for (int unsigned y = 0; y < MAX_KERNEL; y++) begin
         for (int unsigned x = 0; x + 1 < MAX_KERNEL; x++) begin
            w_shift[y][x] = r_window[y][x+1];
         end
      end
      for (int unsigned y = 0; y < MAX_KERNEL; y++) begin
         for (int unsigned x = 0; x < MAX_KERNEL; x++) begin
            if ((y < 32'(r_k)) && (x < 32'(r_k))) begin
               if (x + 1 == 32'(r_k)) begin
                  w_win_next[y][x] = (y + 1 == 32'(r_k)) ? pixel_in : w_lb_col[y];
               end else begin
                  w_win_next[y][x] = w_shift[y][x];
               end
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (frame_start) w_next = S_ACCEPT;
         end
         S_ACCEPT: begin
            if (w_accept) begin
               if (w_valid)     w_next = S_ISSUE;
               else if (w_last) w_next = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (compute_done) w_next = r_last_issue ? S_IDLE : S_ACCEPT;
            else              w_next = S_WAIT;
         end
         S_WAIT: begin
            if (compute_done) w_next = r_last_issue ? S_IDLE : S_ACCEPT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State, registered outputs, counters and window
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state       <= S_IDLE;
         r_pixel_ready <= 1'b0;
         r_start       <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_window      <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_width       <= '0;
         r_height      <= '0;
         r_k           <= KW'(1);
         r_last_issue  <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_pixel_ready <= (w_next == S_ACCEPT);
         r_start       <= (w_next == S_ISSUE);
         r_busy        <= (w_next != S_IDLE);
         r_frame_done  <= (w_next == S_IDLE) && (r_state != S_IDLE);
         if ((r_state == S_IDLE) && frame_start) begin
            r_width      <= img_width;
            r_height     <= img_height;
            r_k          <= w_k_clamped;
            r_col        <= '0;
            r_row        <= '0;
            r_window     <= '0;
            r_last_issue <= 1'b0;
         end else if (w_accept) begin
            r_window     <= w_win_next;
            r_last_issue <= w_last;
            if (w_col_wrap) begin
               r_col <= '0;
               r_row <= r_row + WH'(1);
            end else begin
               r_col <= r_col + WW'(1);
            end
         end
      end
   end

   // Line buffers: contents are don't-care after reset, so no reset term
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int unsigned j = 0; j + 1 < NLB; j++) begin
            r_lb[j][w_col_idx] <= r_lb[j+1][w_col_idx];
         end
         r_lb[NLB-1][w_col_idx] <= pixel_in;
      end
   end

endmodule
